// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch queue instruction-memory and decode-side signal bundle
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] IR;
    logic [31:0] PC4;
    logic        valid;

    modport master (
        output imem_req, imem_addr, IR, PC4, valid,
        input  imem_ack, imem_rdata, en, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, IR, PC4, valid,
        output imem_ack, imem_rdata, en, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue with single outstanding fetch and redirect flush
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fpc;
    logic [31:0]   r_addr;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc4   [DEPTH];

    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic          w_req;
    logic [31:0]   w_addr;
    logic [31:0]   w_rpc_align;
    logic [CW-1:0] w_count_after_pop;

    assign w_valid           = (r_count != '0);
    assign w_pop             = bus.en && w_valid;
    assign w_count_after_pop = r_count - CW'(w_pop);
    assign w_rpc_align       = bus.redirect_pc & ~32'h3;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_req       = 1'b0;
        w_addr      = r_addr;
        case (r_state)
            IDLE: begin
                w_addr = r_fpc;
                // Only issue when a slot is guaranteed free by the time the word returns.
                if (!bus.redirect && (w_count_after_pop < DEPTH_C)) begin
                    w_issue     = 1'b1;
                    w_req       = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_req = 1'b1;
                if (bus.imem_ack) begin
                    w_push      = !bus.redirect;
                    w_state_nxt = IDLE;
                end else if (bus.redirect) begin
                    w_state_nxt = DROP;
                end
            end
            DROP: begin
                w_req = 1'b1;
                if (bus.imem_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gate with reset so the combinational IDLE request drops the instant reset asserts.
    assign bus.imem_req  = w_req && reset;
    assign bus.imem_addr = w_addr;
    assign bus.valid     = w_valid;
    assign bus.IR        = w_valid ? r_instr[r_head] : 32'h0;
    assign bus.PC4       = w_valid ? r_pc4[r_head]   : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_fpc   <= RESET_PC;
            r_addr  <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_addr <= r_fpc;
            end
            if (bus.redirect) begin
                r_fpc   <= w_rpc_align;
                r_count <= '0;
                r_head  <= r_tail;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + PW'(1);
                    r_fpc  <= r_fpc + 32'd4;
                end
                if (w_pop) begin
                    r_head <= r_head + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage is left uninitialised; outputs mask it whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_tail] <= bus.imem_rdata;
            r_pc4[r_tail]   <= r_addr + 32'd4;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized self-checking bench for fetch_queue against a queue-based model
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    logic clk;
    logic reset;
    fetch_queue_if bus();

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    entry_t      q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    int          m_out;   // 0 none, 1 live request, 2 request whose word will be dropped

    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_ir;
    logic [31:0] s_pc4;

    logic [31:0] issue_log[64];
    logic [31:0] pop_log[64];
    int          n_issue;
    int          n_pop;
    int          n_push;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_issue(input string name, input int idx, input logic [31:0] exp);
        chk({name, "_present"}, 32'(idx < n_issue), 32'd1);
        if (idx < n_issue) chk(name, issue_log[idx], exp);
    endtask

    task automatic chk_pop(input string name, input int idx, input logic [31:0] exp);
        chk({name, "_present"}, 32'(idx < n_pop), 32'd1);
        if (idx < n_pop) chk(name, pop_log[idx], exp);
    endtask

    task automatic clear_logs();
        n_issue = 0;
        n_pop   = 0;
        n_push  = 0;
    endtask

    task automatic model_reset();
        q.delete();
        m_fpc  = RESET_PC;
        m_addr = RESET_PC;
        m_out  = 0;
    endtask

    // One clock cycle: called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input logic en_i, input logic redir_i, input logic [31:0] rpc_i, input int ack_pct);
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        pop;
        logic        ack;
        logic [31:0] rdata;
        entry_t      e;
        bus.en          = en_i;
        bus.redirect    = redir_i;
        bus.redirect_pc = rpc_i;
        ack             = (m_out != 0) && (int'($urandom_range(99)) < ack_pct);
        rdata           = $urandom;
        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        @(negedge clk);
        pop = en_i && (q.size() > 0);
        if (m_out != 0) begin
            exp_req  = 1'b1;
            exp_addr = m_addr;
        end else begin
            exp_req  = !redir_i && ((q.size() - int'(pop)) < DEPTH);
            exp_addr = m_fpc;
        end
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.valid;
        s_ir    = bus.IR;
        s_pc4   = bus.PC4;
        chk("imem_req", 32'(s_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", s_addr, exp_addr);
        chk("valid", 32'(s_valid), 32'(q.size() > 0));
        chk("IR", s_ir, (q.size() > 0) ? q[0].instr : 32'h0);
        chk("PC4", s_pc4, (q.size() > 0) ? q[0].pc4 : 32'h0);
        if (m_out == 0 && exp_req && n_issue < 64) begin
            issue_log[n_issue] = s_addr;
            n_issue++;
        end
        if (pop && n_pop < 64) begin
            pop_log[n_pop] = s_pc4;
            n_pop++;
        end
        if (redir_i) begin
            q.delete();
            m_fpc = rpc_i & ~32'h3;
            if (m_out == 1) m_out = ack ? 0 : 2;
            else if (m_out == 2 && ack) m_out = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (m_out == 0 && exp_req) begin
                m_out  = 1;
                m_addr = m_fpc;
            end else if (m_out == 1 && ack) begin
                e.instr = rdata;
                e.pc4   = m_addr + 32'd4;
                q.push_back(e);
                n_push++;
                m_fpc = m_fpc + 32'd4;
                m_out = 0;
            end else if (m_out == 2 && ack) begin
                m_out = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed off the clock edge, with a stray ack while held.
    task automatic do_reset(input int off);
        bus.en       = 1'b0;
        bus.redirect = 1'b0;
        bus.imem_ack = 1'b0;
        #(off);
        reset = 1'b0;
        bus.imem_ack = 1'b1;
        #1;
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_IR", bus.IR, 32'h0);
        chk("rst_PC4", bus.PC4, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        bus.imem_ack = 1'b0;
        reset = 1'b1;
    endtask

    task automatic settle();
        int guard = 0;
        while (m_out != 0 && guard < 20) begin
            cycle(1'b0, 1'b0, 32'h0, 100);
            guard++;
        end
        chk("settle_reached", 32'(m_out == 0), 32'd1);
    endtask

    initial begin
        int guard;
        int en_pct;
        reset           = 1'b0;
        bus.en          = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        model_reset();
        clear_logs();
        #2;
        chk("por_imem_req", 32'(bus.imem_req), 32'd0);
        chk("por_valid", 32'(bus.valid), 32'd0);
        chk("por_IR", bus.IR, 32'h0);
        chk("por_PC4", bus.PC4, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Streaming fetch from reset with prompt acks.
        repeat (8) cycle(1'b1, 1'b0, 32'h0, 100);
        chk_issue("seq_addr0", 0, 32'h3000);
        chk_issue("seq_addr1", 1, 32'h3004);
        chk_issue("seq_addr2", 2, 32'h3008);
        chk_pop("seq_pc4_0", 0, 32'h3004);
        chk_pop("seq_pc4_1", 1, 32'h3008);
        chk_pop("seq_pc4_2", 2, 32'h300C);

        // Stall fills exactly DEPTH entries, then drains in order.
        settle();
        cycle(1'b0, 1'b1, 32'h4000, 0);
        clear_logs();
        repeat (10) cycle(1'b0, 1'b0, 32'h0, 100);
        chk("fill_pushes", 32'(n_push), 32'(DEPTH));
        chk("fill_req_off", 32'(s_req), 32'd0);
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 0);
        chk_pop("drain0", 0, 32'h4004);
        chk_pop("drain1", 1, 32'h4008);
        chk_pop("drain2", 2, 32'h400C);
        chk_pop("drain3", 3, 32'h4010);
        chk("drain_count", 32'(n_pop), 32'd4);

        // Redirect while waiting: old word dropped, restart at aligned target.
        settle();
        cycle(1'b0, 1'b1, 32'h3010, 0);
        cycle(1'b0, 1'b0, 32'h0, 0);
        chk("wait_addr", s_addr, 32'h3010);
        cycle(1'b0, 1'b1, 32'h3103, 0);
        repeat (2) begin
            cycle(1'b0, 1'b0, 32'h0, 0);
            chk("drop_req", 32'(s_req), 32'd1);
            chk("drop_addr", s_addr, 32'h3010);
            chk("drop_valid", 32'(s_valid), 32'd0);
        end
        cycle(1'b0, 1'b0, 32'h0, 100);
        cycle(1'b0, 1'b0, 32'h0, 0);
        chk("redir_addr", s_addr, 32'h3100);
        chk("redir_valid", 32'(s_valid), 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 100);
        cycle(1'b0, 1'b0, 32'h0, 0);
        chk("redir_first_valid", 32'(s_valid), 32'd1);
        chk("redir_first_pc4", s_pc4, 32'h3104);

        // Redirect coinciding with ack and pop at count=2.
        settle();
        cycle(1'b0, 1'b1, 32'h5000, 0);
        guard = 0;
        while (!(q.size() == 2 && m_out == 1) && guard < 20) begin
            cycle(1'b0, 1'b0, 32'h0, 100);
            guard++;
        end
        chk("c2_reached", 32'(q.size() == 2 && m_out == 1), 32'd1);
        cycle(1'b1, 1'b1, 32'h6000, 100);
        chk("c2_valid_before", 32'(s_valid), 32'd1);
        cycle(1'b0, 1'b0, 32'h0, 0);
        chk("c2_valid_after", 32'(s_valid), 32'd0);
        chk("c2_next_addr", s_addr, 32'h6000);

        // Address wrap at the top of the 32-bit space.
        settle();
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 0);
        clear_logs();
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 100);
        chk_issue("wrap_addr0", 0, 32'hFFFF_FFFC);
        chk_issue("wrap_addr1", 1, 32'h0000_0000);
        chk_pop("wrap_pc4", 0, 32'h0000_0000);

        // Reset pulse in the middle of an outstanding request.
        settle();
        cycle(1'b0, 1'b1, 32'h7000, 0);
        cycle(1'b0, 1'b0, 32'h0, 0);
        chk("mid_wait_live", 32'(m_out), 32'd1);
        do_reset(3);
        clear_logs();
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 100);
        chk_issue("post_reset_addr", 0, 32'h3000);

        // Randomized traffic with occasional redirects and resets.
        en_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(2))
                    0:       en_pct = 10;
                    1:       en_pct = 50;
                    default: en_pct = 90;
                endcase
            end
            if ($urandom_range(999) < 4) begin
                do_reset(int'($urandom_range(1, 8)));
            end else begin
                cycle(int'($urandom_range(99)) < en_pct,
                      $urandom_range(24) == 0,
                      $urandom,
                      int'($urandom_range(30, 90)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4 (power of two, 2..16), is the prefetch queue entry count.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 imem_req  output  1  instruction-memory read request, held until acknowledged.
REQ-006 imem_addr  output  32  word-aligned fetch address, stable while imem_req=1.
REQ-007 imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  32  instruction word returned by memory.
REQ-009 en  input  1  decode-stage register load enable (0 = stall); consumes the head entry when valid=1.
REQ-010 redirect  input  1  branch/jump taken; flush and restart at redirect_pc.
REQ-011 redirect_pc  input  32  restart address; bits [1:0] ignored and treated as 0.
REQ-012 IR  output  32  head instruction toward the decode register.
REQ-013 PC4  output  32  head instruction address + 4.
REQ-014 valid  output  1  head entry present.

Function
REQ-015 Internal state SHALL be: fetch PC fpc, circular queue of DEPTH {instr, pc4} entries, head/tail pointers, count (0..DEPTH), and FSM {IDLE, WAIT, DROP}.
REQ-016 At most one memory request SHALL be outstanding.
REQ-017 IDLE: if redirect=0 and count + 1 <= DEPTH after this cycle's pop, assert imem_req with imem_addr=fpc and go to WAIT; otherwise imem_req=0.
REQ-018 WAIT: imem_req=1, imem_addr unchanged; on imem_ack with redirect=0, push {imem_rdata, imem_addr+4} at tail, fpc <= fpc+4, go to IDLE.
REQ-019 WAIT with redirect=1 and imem_ack=0 SHALL go to DROP, keeping imem_req and imem_addr unchanged.
REQ-020 DROP: imem_req=1 until imem_ack; the returned word SHALL be discarded, then go to IDLE.
REQ-021 WAIT or DROP with imem_ack=1 in the same cycle as redirect=1 SHALL discard the word and go to IDLE.
REQ-022 Issue rule SHALL guarantee a push never occurs when count=DEPTH (no overflow, no drop of valid data).
REQ-023 valid = (count != 0); IR/PC4 SHALL show the head entry combinationally from registers, and 32'h0/32'h0 when empty (bubble).
REQ-024 Pop SHALL occur when en=1 and valid=1; en=1 with valid=0 SHALL change nothing.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-026 redirect=1 SHALL, in that cycle, set count=0, head=tail, and fpc <= {redirect_pc[31:2],2'b00}; it overrides same-cycle push and pop.
REQ-027 redirect while en=0 SHALL still flush.
REQ-028 fpc and pc4 arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 = 0); pointers SHALL wrap modulo DEPTH.
REQ-029 First request after reset or redirect SHALL appear on imem_req no later than the next rising edge.
REQ-030 Request-to-decode latency SHALL be one cycle: entry pushed on the ack edge is visible on IR/valid in the following cycle.

Reset
REQ-031 reset=0 SHALL asynchronously set fpc=RESET_PC, count=0, head=tail=0, FSM=IDLE, imem_req=0, valid=0, IR=0, PC4=0.
REQ-032 Reset asserted during WAIT or DROP SHALL abandon the request; an ack arriving while reset=0 or in the first cycle after release SHALL be ignored unless a new request is pending.
REQ-033 Queue storage contents need not be cleared; no output may depend on them while count=0.

Verification
REQ-034 Release reset, ack every request after one cycle, en=1 -> imem_addr sequence 0x3000, 0x3004, 0x3008; IR matches rdata with PC4 0x3004, 0x3008, 0x300C.
REQ-035 en=0 for 10 cycles, immediate acks -> exactly 4 pushes then imem_req=0, count=4; en=1 drains in order, no word lost or duplicated.
REQ-036 redirect=1 with redirect_pc=0x3103 while WAIT on 0x3010 -> FSM DROP, ack of 0x3010 discarded, next imem_addr=0x3100, valid=0 until its ack.
REQ-037 redirect same cycle as ack and en=1 with count=2 -> count=0, word discarded, next request at redirect_pc.
REQ-038 fpc forced by redirect to 0xFFFF_FFFC -> IR PC4=0x0000_0000, next imem_addr=0x0000_0000.
REQ-039 reset=0 pulse mid-WAIT, not clock-aligned -> outputs zero immediately; after release first imem_addr=0x3000.
